// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit width, default buffer depth and the link
// record used by both the sender and the receiver side of a credit link.
package noc_pkg;

    localparam int FLIT_W = 32;

    typedef logic [FLIT_W-1:0] flit_t;

    localparam int DEFAULT_BUF_DEPTH = 4;

    // One flit on the wire plus its valid qualifier.
    typedef struct packed {
        flit_t data;
        logic  valid;
    } flit_link_t;

    // Width needed to hold an occupancy value in the range 0..depth.
    function automatic int occupancy_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/noc_input_buffer_if.sv
// Flit link seen from the router input port. The master side is the
// upstream sender plus the downstream consumer; the slave side is the
// input buffer itself.
interface noc_input_buffer_if #(
    parameter int FLIT_W = noc_pkg::FLIT_W
);
    import noc_pkg::*;

    logic [FLIT_W-1:0] flit_in;
    logic              flit_valid_in;
    logic [FLIT_W-1:0] flit_out;
    logic              flit_valid_out;
    logic              flit_pop;
    logic              credit_out;

    modport master (
        output flit_in,
        output flit_valid_in,
        output flit_pop,
        input  flit_out,
        input  flit_valid_out,
        input  credit_out
    );

    modport slave (
        input  flit_in,
        input  flit_valid_in,
        input  flit_pop,
        output flit_out,
        output flit_valid_out,
        output credit_out
    );

endinterface

// File: rtl/noc_flit_fifo.sv
// DEPTH-entry first-word-fall-through flit FIFO with occupancy counter.
// Owns the push-accept and effective-pop decisions so the wrapper can
// derive credits and overflow from them without re-deciding anything.
module noc_flit_fifo #(
    parameter int FLIT_W = noc_pkg::FLIT_W,
    parameter int DEPTH  = noc_pkg::DEFAULT_BUF_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] push_data,
    input  logic              push_valid,
    input  logic              pop_req,
    output logic [FLIT_W-1:0] head_data,
    output logic              head_valid,
    output logic [CNT_W-1:0]  count,
    output logic              pop_eff,
    output logic              push_reject
);
    import noc_pkg::*;

    localparam int               AW       = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push_ok;

    // Accept/pop decisions. A pop on an empty FIFO does nothing, so a
    // same-cycle push into an empty FIFO cannot bypass to the consumer.
    // A push into a full FIFO is only taken when a real pop frees a slot.
    always_comb begin
        pop_eff     = pop_req && (count != '0);
        push_ok     = push_valid && ((count < FULL_CNT) || pop_eff);
        push_reject = push_valid && !push_ok;
    end

    // Flit storage; contents are never cleared, the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at AW bits; count tracks accepted minus popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_eff})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_data  = mem[rd_ptr];
    assign head_valid = (count != '0);

endmodule

// File: rtl/noc_input_buffer.sv
// Router input-port buffer for the credit-based NoC link. Stores incoming
// flits, presents the head flit downstream and returns one credit upstream
// per flit consumed, one cycle after the pop.
// Optional build macro OVF_CHECK_EN: adds the sticky overflow_err output
// and an assertion on every rejected push.
module noc_input_buffer #(
    parameter int FLIT_W = noc_pkg::FLIT_W,
    parameter int DEPTH  = noc_pkg::DEFAULT_BUF_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    noc_input_buffer_if.slave bus,
    output logic [CNT_W-1:0] count
`ifdef OVF_CHECK_EN
    ,
    output logic             overflow_err
`endif
);
    import noc_pkg::*;

    logic [FLIT_W-1:0] head_data;
    logic              head_valid;
    logic              pop_eff;
    logic              push_reject;
    logic              credit_p1;

    noc_flit_fifo #(
        .FLIT_W (FLIT_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_data   (bus.flit_in),
        .push_valid  (bus.flit_valid_in),
        .pop_req     (bus.flit_pop),
        .head_data   (head_data),
        .head_valid  (head_valid),
        .count       (count),
        .pop_eff     (pop_eff),
        .push_reject (push_reject)
    );

    assign bus.flit_out       = head_data;
    assign bus.flit_valid_out = head_valid;

    // Credit return: registered copy of the effective pop. Reset drops any
    // pending credit because the sender reloads its full allowance anyway.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_p1 <= 1'b0;
        end else begin
            credit_p1 <= pop_eff;
        end
    end

    assign bus.credit_out = credit_p1;

`ifdef OVF_CHECK_EN
    // Sticky overflow: set the cycle after any rejected push, held until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_err <= 1'b0;
        end else if (push_reject) begin
            overflow_err <= 1'b1;
        end
    end

    // A rejected push means the sender violated its credit count.
    a_no_rejected_push: assert property (@(posedge clk) disable iff (rst) !push_reject);
`else
    // Rejected pushes are dropped silently in this build.
    logic unused_push_reject;
    assign unused_push_reject = push_reject;
`endif

endmodule

// File: tb/tb_noc_input_buffer.sv
// Testbench for noc_input_buffer: hand-built vector table for the directed
// corners, hand sequences for reset, and a randomized phase against a
// queue-based reference model of the buffer and its credit return.
module tb_noc_input_buffer;

    localparam int FLIT_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] count;
`ifdef OVF_CHECK_EN
    logic             overflow_err;
`endif

    noc_input_buffer_if #(.FLIT_W(FLIT_W)) bus ();

    noc_input_buffer #(
        .FLIT_W (FLIT_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .count (count)
`ifdef OVF_CHECK_EN
        ,
        .overflow_err (overflow_err)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [FLIT_W-1:0] q[$];
    bit                cr_exp;
    bit                ovf_exp;
    int                accepted;
    int                returned;

    typedef struct {
        bit          push;
        logic [31:0] data;
        bit          pop;
        bit          exp_valid;
        logic [31:0] exp_out;
        int          exp_count;
        bit          exp_credit;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Apply one cycle of inputs, then advance the reference model.
    task automatic step(input bit do_rst, input bit push, input logic [31:0] data, input bit pop);
        bit pe;
        bit acc;
        rst               = do_rst;
        bus.flit_valid_in = push;
        bus.flit_in       = data;
        bus.flit_pop      = pop;
        @(posedge clk);
        #1;
        if (do_rst) begin
            q.delete();
            cr_exp   = 1'b0;
            ovf_exp  = 1'b0;
            accepted = 0;
            returned = 0;
        end else begin
            pe  = pop && (q.size() > 0);
            acc = push && ((q.size() < DEPTH) || pe);
            if (pe) void'(q.pop_front());
            if (acc) begin
                q.push_back(data);
                accepted++;
            end
            if (push && !acc) ovf_exp = 1'b1;
            cr_exp = pe;
            if (bus.credit_out === 1'b1) returned++;
        end
    endtask

    task automatic model_compare(input string tag);
        check({tag, "_valid"}, {31'b0, bus.flit_valid_out}, {31'b0, q.size() != 0});
        check({tag, "_count"}, 32'(count), 32'(q.size()));
        if (q.size() != 0) check({tag, "_data"}, bus.flit_out, q[0]);
        check({tag, "_credit"}, {31'b0, bus.credit_out}, {31'b0, cr_exp});
        check({tag, "_credit_cons"}, {31'b0, returned <= accepted}, 32'd1);
`ifdef OVF_CHECK_EN
        check({tag, "_ovf"}, {31'b0, overflow_err}, {31'b0, ovf_exp});
`endif
    endtask

    function automatic void add(input bit push, input logic [31:0] data, input bit pop,
                                input bit ev, input logic [31:0] eo, input int ec, input bit ecr);
        vec_t v;
        v = '{push, data, pop, ev, eo, ec, ecr};
        vecs.push_back(v);
    endfunction

    initial begin
        // Directed table, starting from an empty buffer after reset.
        add(1, 32'hA0, 0, 1, 32'hA0, 1, 0);
        add(1, 32'hA1, 0, 1, 32'hA0, 2, 0);
        add(1, 32'hA2, 0, 1, 32'hA0, 3, 0);
        add(1, 32'hA3, 0, 1, 32'hA0, 4, 0);
        add(1, 32'hC0, 0, 1, 32'hA0, 4, 0);  // full, no pop: C0 dropped
        add(1, 32'hB0, 1, 1, 32'hA1, 4, 1);  // full push+pop: accepted
        add(0, 32'h0,  1, 1, 32'hA2, 3, 1);
        add(0, 32'h0,  1, 1, 32'hA3, 2, 1);
        add(0, 32'h0,  1, 1, 32'hB0, 1, 1);
        add(0, 32'h0,  0, 1, 32'hB0, 1, 0);
        add(0, 32'h0,  1, 0, 32'h0,  0, 1);
        add(0, 32'h0,  1, 0, 32'h0,  0, 0);  // pop on empty: no credit
        add(1, 32'hD0, 1, 1, 32'hD0, 1, 0);  // push+pop on empty: count 1
        add(0, 32'h0,  1, 0, 32'h0,  0, 1);
        for (int k = 0; k < 5; k++) begin      // alternating, crosses pointer wrap
            add(1, 32'hE0 + k, 0, 1, 32'hE0 + k, 1, 0);
            add(0, 32'h0,      1, 0, 32'h0,      0, 1);
        end

        // Reset then idle
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0);
            check($sformatf("idle%0d_count", i), 32'(count), 32'd0);
            check($sformatf("idle%0d_valid", i), {31'b0, bus.flit_valid_out}, 32'd0);
            check($sformatf("idle%0d_credit", i), {31'b0, bus.credit_out}, 32'd0);
        end

        // Directed table
        foreach (vecs[i]) begin
            step(0, vecs[i].push, vecs[i].data, vecs[i].pop);
            check($sformatf("tbl%0d_valid", i), {31'b0, bus.flit_valid_out}, {31'b0, vecs[i].exp_valid});
            if (vecs[i].exp_valid)
                check($sformatf("tbl%0d_out", i), bus.flit_out, vecs[i].exp_out);
            check($sformatf("tbl%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
            check($sformatf("tbl%0d_credit", i), {31'b0, bus.credit_out}, {31'b0, vecs[i].exp_credit});
`ifdef OVF_CHECK_EN
            check($sformatf("tbl%0d_ovf", i), {31'b0, overflow_err}, {31'b0, (i >= 4)});
`endif
        end

        // Reset mid-stream with a pop request pending: no credits for flushed flits
        step(0, 1, 32'hF0, 0);
        step(0, 1, 32'hF1, 0);
        step(0, 1, 32'hF2, 0);
        check("mid_pre_count", 32'(count), 32'd3);
        step(1, 0, 0, 1);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_valid", {31'b0, bus.flit_valid_out}, 32'd0);
        check("mid_rst_credit", {31'b0, bus.credit_out}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1);
            check($sformatf("mid_post%0d_credit", i), {31'b0, bus.credit_out}, 32'd0);
            check($sformatf("mid_post%0d_count", i), 32'(count), 32'd0);
        end
`ifdef OVF_CHECK_EN
        check("mid_ovf_cleared", {31'b0, overflow_err}, 32'd0);
`endif

        // Randomized phase against the reference model
        for (int i = 0; i < 600; i++) begin
            bit r;
            bit pu;
            bit po;
            r  = ($urandom_range(0, 99) == 0);
            pu = ($urandom_range(0, 99) < 60);
            po = ($urandom_range(0, 99) < 50);
            step(r, pu, $urandom, po);
            model_compare($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
